// File: rtl/snoop_cache_node.sv
// Per-processor L1 MSI controller on a shared snooping bus, direct-mapped.
// Define SNOOP_MESI_EN to add the Exclusive state (MESI).
module snoop_cache_node #(
   parameter int                PROC_W    = 2,
   parameter logic [PROC_W-1:0] PROC_ID   = 2'b01,
   parameter int                TAG_W     = 4,
   parameter int                DATA_W    = 8,
   parameter int                NUM_LINES = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [PROC_W-1:0] proc,
   input  logic [1:0]        opcode,
   input  logic [TAG_W-1:0]  tag,
   input  logic [DATA_W-1:0] data,
   output logic              done,
   output logic [DATA_W-1:0] read_data,
   output logic              bus_req,
   input  logic              bus_grant,
   output logic              bus_valid,
   output logic [1:0]        bus_cmd,
   output logic [TAG_W-1:0]  bus_tag,
   input  logic              snoop_valid,
   input  logic [1:0]        snoop_cmd,
   input  logic [TAG_W-1:0]  snoop_tag,
   output logic              flush_valid,
   output logic [DATA_W-1:0] flush_data,
   input  logic              flush_in_valid,
   input  logic [DATA_W-1:0] flush_in_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [TAG_W-1:0]  mem_tag,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] data_mem,
   input  logic              mem_ack
);

   localparam int IDX_W   = $clog2(NUM_LINES);
   localparam int INSTR_W = PROC_W + 2 + TAG_W + DATA_W;

   localparam logic [1:0] ST_I = 2'b00;
   localparam logic [1:0] ST_S = 2'b01;
   localparam logic [1:0] ST_M = 2'b10;
   localparam logic [1:0] ST_E = 2'b11;
   localparam logic [1:0] CMD_RD  = 2'b00;
   localparam logic [1:0] CMD_WR  = 2'b01;
   localparam logic [1:0] CMD_INV = 2'b10;

`ifdef SNOOP_MESI_EN
   localparam logic MESI = 1'b1;
`else
   localparam logic MESI = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE, LOOKUP, WB_VICTIM, BUS_ARB,
      BUS_SEND, FILL_WAIT, MEM_RD, COMPLETE
   } state_t;

   state_t state, nxt;

   logic [1:0]        lst  [NUM_LINES];
   logic [TAG_W-1:0]  ltag [NUM_LINES];
   logic [DATA_W-1:0] ldat [NUM_LINES];

   logic [INSTR_W-1:0] last_instr, cur_instr;
   logic               new_instr, is_emit, op_nop;
   logic [IDX_W-1:0]   idx, sidx;
   logic               hit, wr_silent;
   logic [1:0]         pend_cmd, nxt_cmd;

   logic              e_we, rd_we;
   logic [1:0]        e_st;
   logic [DATA_W-1:0] e_dat, rd_val;

   logic       s_hit, s_flush, s_we, snp_cur;
   logic [1:0] s_st, s_nst;

   assign cur_instr = {proc, opcode, tag, data};
   assign new_instr = cur_instr != last_instr;
   assign is_emit   = proc == PROC_ID;
   assign op_nop    = opcode[1];
   assign idx       = tag[IDX_W-1:0];
   assign sidx      = snoop_tag[IDX_W-1:0];
   assign hit       = lst[idx] != ST_I && ltag[idx] == tag;
   assign wr_silent = lst[idx] == ST_M || (MESI && lst[idx] == ST_E);

   // Snoops are ignored only while our own command is on the bus
   assign s_st    = lst[sidx];
   assign s_hit   = snoop_valid && s_st != ST_I && ltag[sidx] == snoop_tag
                    && state != BUS_SEND;
   assign s_flush = s_hit && s_st == ST_M && snoop_cmd != 2'b11;
   assign s_we    = s_hit && (snoop_cmd == CMD_WR || snoop_cmd == CMD_INV ||
                              (snoop_cmd == CMD_RD && s_st != ST_S));
   assign s_nst   = (snoop_cmd == CMD_RD) ? ST_S : ST_I;
   assign snp_cur = s_we && sidx == idx;

   assign bus_cmd = bus_valid ? pend_cmd : 2'b00;
   assign bus_tag = bus_valid ? tag : '0;

   always_comb begin
      nxt       = state;
      nxt_cmd   = pend_cmd;
      e_we      = 1'b0;
      e_st      = ST_I;
      e_dat     = data;
      rd_we     = 1'b0;
      rd_val    = ldat[idx];
      bus_req   = 1'b0;
      bus_valid = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_tag   = '0;
      mem_wdata = '0;
      unique case (state)
         IDLE:
            if (is_emit && (new_instr || !done))
               nxt = op_nop ? COMPLETE : LOOKUP;
         LOOKUP:
            if (snp_cur) begin
               nxt = LOOKUP;
            end else if (hit && opcode == 2'b00) begin
               rd_we = 1'b1;
               nxt   = COMPLETE;
            end else if (hit && wr_silent) begin
               e_we = 1'b1;
               e_st = ST_M;
               nxt  = COMPLETE;
            end else if (hit) begin
               nxt_cmd = CMD_INV;
               nxt     = BUS_ARB;
            end else begin
               nxt_cmd = (opcode == 2'b00) ? CMD_RD : CMD_WR;
               nxt     = (lst[idx] == ST_M) ? WB_VICTIM : BUS_ARB;
            end
         WB_VICTIM: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_tag   = ltag[idx];
            mem_wdata = ldat[idx];
            if (mem_ack) nxt = BUS_ARB;
         end
         BUS_ARB: begin
            bus_req = 1'b1;
            if (snp_cur) nxt = LOOKUP;
            else if (bus_grant) nxt = BUS_SEND;
         end
         BUS_SEND: begin
            bus_req   = 1'b1;
            bus_valid = 1'b1;
            if (pend_cmd == CMD_RD) begin
               nxt = FILL_WAIT;
            end else begin
               e_we = 1'b1;
               e_st = ST_M;
               nxt  = COMPLETE;
            end
         end
         FILL_WAIT: begin
            bus_req = 1'b1;
            if (flush_in_valid) begin
               e_we   = 1'b1;
               e_st   = ST_S;
               e_dat  = flush_in_data;
               rd_we  = 1'b1;
               rd_val = flush_in_data;
               nxt    = COMPLETE;
            end else begin
               nxt = MEM_RD;
            end
         end
         MEM_RD: begin
            bus_req = 1'b1;
            mem_req = 1'b1;
            mem_tag = tag;
            if (mem_ack) begin
               e_we   = 1'b1;
               e_st   = MESI ? ST_E : ST_S;
               e_dat  = data_mem;
               rd_we  = 1'b1;
               rd_val = data_mem;
               nxt    = COMPLETE;
            end
         end
         COMPLETE: nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pend_cmd    <= CMD_RD;
         last_instr  <= '1;
         done        <= 1'b0;
         read_data   <= '0;
         flush_valid <= 1'b0;
         flush_data  <= '0;
         for (int i = 0; i < NUM_LINES; i++) begin
            lst[i]  <= ST_I;
            ltag[i] <= '0;
            ldat[i] <= '0;
         end
      end else begin
         state       <= nxt;
         pend_cmd    <= nxt_cmd;
         last_instr  <= cur_instr;
         flush_valid <= s_flush;
         flush_data  <= s_flush ? ldat[sidx] : '0;
         if (new_instr) done <= 1'b0;
         else if (state == COMPLETE || !is_emit) done <= 1'b1;
         if (rd_we) read_data <= rd_val;
         if (s_we) lst[sidx] <= s_nst;
         // A fill replaces the whole line, so it overrides a snoop on the victim
         if (e_we) begin
            lst[idx]  <= e_st;
            ltag[idx] <= tag;
            ldat[idx] <= e_dat;
         end
      end
   end

endmodule
